// File: rtl/agc_ctrl_pkg.sv
// Shared definitions for the AGC sequencing controller:
// state encoding, parameter defaults and a counter-width helper.
package agc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } agc_state_t;

    localparam int CFG_W            = 16;
    localparam int DEF_GAIN_WIDTH   = 16;
    localparam int DEF_GAIN_HIGH    = 2048;
    localparam int DEF_GAIN_LOW     = 0;
    localparam int DEF_SETTLE_TOL   = 4;
    localparam int DEF_SETTLE_COUNT = 8;
    localparam int DEF_LOSE_TOL     = 64;
    localparam int DEF_ACQ_TIMEOUT  = 256;
    localparam int DEF_SAT_COUNT    = 16;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/agc_settle_det.sv
// Gain-step tracker: keeps the previous gain, measures |delta| and counts
// consecutive settled and saturated updates for the sequencing FSM.
module agc_settle_det
    import agc_ctrl_pkg::*;
#(
    parameter int GAIN_WIDTH   = DEF_GAIN_WIDTH,
    parameter int GAIN_HIGH    = DEF_GAIN_HIGH,
    parameter int GAIN_LOW     = DEF_GAIN_LOW,
    parameter int SETTLE_TOL   = DEF_SETTLE_TOL,
    parameter int SETTLE_COUNT = DEF_SETTLE_COUNT,
    parameter int LOSE_TOL     = DEF_LOSE_TOL,
    parameter int SAT_COUNT    = DEF_SAT_COUNT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_sat_clear,
    input  logic                         i_upd,
    input  logic signed [GAIN_WIDTH-1:0] i_gain,
    output logic                         o_settled_hit,
    output logic                         o_lost_hit,
    output logic                         o_sat_hit
);

    localparam int SW = cnt_w(SETTLE_COUNT);
    localparam int TW = cnt_w(SAT_COUNT);
    localparam logic [GAIN_WIDTH:0]          L_SETTLE_TOL = (GAIN_WIDTH+1)'(SETTLE_TOL);
    localparam logic [GAIN_WIDTH:0]          L_LOSE_TOL   = (GAIN_WIDTH+1)'(LOSE_TOL);
    localparam logic signed [GAIN_WIDTH-1:0] L_HIGH       = GAIN_WIDTH'(GAIN_HIGH);
    localparam logic signed [GAIN_WIDTH-1:0] L_LOW        = GAIN_WIDTH'(GAIN_LOW);
    localparam logic [SW-1:0]                L_SC         = SW'(SETTLE_COUNT);
    localparam logic [TW-1:0]                L_TC         = TW'(SAT_COUNT);

    logic signed [GAIN_WIDTH-1:0] r_prev;
    logic                         r_have_prev;
    logic [SW-1:0]                r_settle_cnt;
    logic [TW-1:0]                r_sat_cnt;

    logic signed [GAIN_WIDTH:0]   w_delta;
    logic [GAIN_WIDTH:0]          w_abs;
    logic                         w_small;
    logic                         w_big;
    logic                         w_is_sat;
    logic [SW-1:0]                w_settle_nxt;
    logic [TW-1:0]                w_sat_nxt;

    // One extra bit so the difference of two extreme gains cannot wrap.
    assign w_delta  = {i_gain[GAIN_WIDTH-1], i_gain} - {r_prev[GAIN_WIDTH-1], r_prev};
    assign w_abs    = w_delta[GAIN_WIDTH] ? $unsigned(-w_delta) : $unsigned(w_delta);
    assign w_small  = (w_abs <= L_SETTLE_TOL);
    assign w_big    = (w_abs > L_LOSE_TOL);
    assign w_is_sat = (i_gain >= L_HIGH) || (i_gain <= L_LOW);

    always_comb begin
        w_settle_nxt = r_settle_cnt;
        if (i_upd && r_have_prev) begin
            if (!w_small)
                w_settle_nxt = '0;
            else if (r_settle_cnt != L_SC)
                w_settle_nxt = r_settle_cnt + SW'(1);
        end
    end

    always_comb begin
        w_sat_nxt = r_sat_cnt;
        if (i_upd) begin
            if (!w_is_sat)
                w_sat_nxt = '0;
            else if (r_sat_cnt != L_TC)
                w_sat_nxt = r_sat_cnt + TW'(1);
        end
    end

    assign o_settled_hit = i_upd && r_have_prev && w_small && (w_settle_nxt == L_SC);
    assign o_lost_hit    = i_upd && r_have_prev && w_big;
    assign o_sat_hit     = (w_sat_nxt == L_TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_have_prev  <= 1'b0;
            r_settle_cnt <= '0;
        end else if (i_clear) begin
            r_prev       <= '0;
            r_have_prev  <= 1'b0;
            r_settle_cnt <= '0;
        end else if (i_upd) begin
            r_prev       <= i_gain;
            r_have_prev  <= 1'b1;
            r_settle_cnt <= w_settle_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_cnt <= '0;
        else if (i_sat_clear)
            r_sat_cnt <= '0;
        else
            r_sat_cnt <= w_sat_nxt;
    end

endmodule

// File: rtl/agc_ctrl.sv
// AGC sequencing controller: acquisition/track/hold FSM, shadowed config and
// datapath reset generation.
//   state | meaning
//   IDLE  | AGC held in reset, loop disabled
//   ACQ   | acquiring, waiting for settled gain (timeout restarts the AGC)
//   TRACK | locked, watching for gain jumps or reference changes
//   HOLD  | gain frozen, returns to the state it was entered from
module agc_ctrl
    import agc_ctrl_pkg::*;
#(
    parameter int GAIN_WIDTH   = DEF_GAIN_WIDTH,
    parameter int GAIN_HIGH    = DEF_GAIN_HIGH,
    parameter int GAIN_LOW     = DEF_GAIN_LOW,
    parameter int SETTLE_TOL   = DEF_SETTLE_TOL,
    parameter int SETTLE_COUNT = DEF_SETTLE_COUNT,
    parameter int LOSE_TOL     = DEF_LOSE_TOL,
    parameter int ACQ_TIMEOUT  = DEF_ACQ_TIMEOUT,
    parameter int SAT_COUNT    = DEF_SAT_COUNT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         freeze,
    input  logic                         cfg_we,
    input  logic [CFG_W-1:0]             cfg_ref_pow,
    input  logic [CFG_W-1:0]             cfg_acq_coef,
    input  logic [CFG_W-1:0]             cfg_trk_coef,
    input  logic signed [GAIN_WIDTH-1:0] gain_in,
    input  logic                         gain_in_valid,
    output logic [CFG_W-1:0]             ref_pow,
    output logic [CFG_W-1:0]             error_coef,
    output logic                         agc_rst,
    output logic [1:0]                   state,
    output logic                         locked,
    output logic                         sat,
    output logic                         cfg_pending
);

    localparam int            UW         = cnt_w(ACQ_TIMEOUT);
    localparam logic [UW-1:0] L_UPD_LAST = UW'(ACQ_TIMEOUT - 1);

    logic [1:0]       r_sync;
    agc_state_t       r_state, r_ret, w_nxt;
    logic [UW-1:0]    r_upd_cnt;
    logic [CFG_W-1:0] r_sh_ref, r_sh_acq, r_sh_trk;
    logic [CFG_W-1:0] r_act_ref, r_act_acq, r_act_trk;
    logic [CFG_W-1:0] r_error_coef;
    logic             r_cfg_pending, r_agc_rst, r_locked, r_sat;

    logic             w_run, w_upd, w_settled, w_lost, w_sat_hit;
    logic             w_timeout, w_apply, w_ref_chg, w_clr, w_det_clr;
    logic [CFG_W-1:0] w_acq_nxt, w_trk_nxt;

    // Reset assertion is immediate; release reaches the FSM two clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sync <= 2'b00;
        else
            r_sync <= {r_sync[0], 1'b1};
    end

    assign w_run     = r_sync[1];
    assign w_upd     = w_run && enable && !freeze && gain_in_valid &&
                       (r_state == ST_ACQ || r_state == ST_TRACK);
    assign w_timeout = w_upd && (r_state == ST_ACQ) && !w_settled && (r_upd_cnt == L_UPD_LAST);
    assign w_apply   = r_cfg_pending && !cfg_we &&
                       (gain_in_valid || r_state == ST_IDLE || r_state == ST_HOLD);
    assign w_ref_chg = w_apply && (r_sh_ref != r_act_ref);
    assign w_acq_nxt = w_apply ? r_sh_acq : r_act_acq;
    assign w_trk_nxt = w_apply ? r_sh_trk : r_act_trk;
    assign w_det_clr = (r_state == ST_IDLE) || w_clr;

    agc_settle_det #(
        .GAIN_WIDTH   (GAIN_WIDTH),
        .GAIN_HIGH    (GAIN_HIGH),
        .GAIN_LOW     (GAIN_LOW),
        .SETTLE_TOL   (SETTLE_TOL),
        .SETTLE_COUNT (SETTLE_COUNT),
        .LOSE_TOL     (LOSE_TOL),
        .SAT_COUNT    (SAT_COUNT)
    ) u_settle_det (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_det_clr),
        .i_sat_clear   (r_state == ST_IDLE),
        .i_upd         (w_upd),
        .i_gain        (gain_in),
        .o_settled_hit (w_settled),
        .o_lost_hit    (w_lost),
        .o_sat_hit     (w_sat_hit)
    );

    always_comb begin
        w_nxt = r_state;
        w_clr = 1'b0;
        if (!w_run || !enable) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_nxt = ST_ACQ;
                ST_ACQ: begin
                    if (freeze)
                        w_nxt = ST_HOLD;
                    else if (w_settled)
                        w_nxt = ST_TRACK;
                    else if (w_timeout)
                        w_clr = 1'b1;
                end
                ST_TRACK: begin
                    if (freeze) begin
                        w_nxt = ST_HOLD;
                    end else if (w_lost || w_ref_chg) begin
                        w_nxt = ST_ACQ;
                        w_clr = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!freeze)
                        w_nxt = r_ret;
                end
                default:  w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ret        <= ST_ACQ;
            r_upd_cnt    <= '0;
            r_agc_rst    <= 1'b1;
            r_error_coef <= '0;
            r_locked     <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if ((r_state == ST_ACQ || r_state == ST_TRACK) && w_nxt == ST_HOLD)
                r_ret <= r_state;
            if (w_clr || w_nxt == ST_IDLE || w_nxt == ST_TRACK)
                r_upd_cnt <= '0;
            else if (w_upd && r_state == ST_ACQ)
                r_upd_cnt <= r_upd_cnt + UW'(1);
            r_agc_rst <= (w_nxt == ST_IDLE) || w_timeout;
            case (w_nxt)
                ST_ACQ:   r_error_coef <= w_acq_nxt;
                ST_TRACK: r_error_coef <= w_trk_nxt;
                default:  r_error_coef <= '0;
            endcase
            r_locked <= (w_nxt == ST_TRACK) || (w_nxt == ST_HOLD && r_locked);
            r_sat    <= (w_nxt != ST_IDLE) && w_sat_hit;
        end
    end

    // A write coinciding with a strobe re-arms the shadow and defers the copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_ref      <= '0;
            r_sh_acq      <= '0;
            r_sh_trk      <= '0;
            r_act_ref     <= '0;
            r_act_acq     <= '0;
            r_act_trk     <= '0;
            r_cfg_pending <= 1'b0;
        end else if (cfg_we) begin
            r_sh_ref      <= cfg_ref_pow;
            r_sh_acq      <= cfg_acq_coef;
            r_sh_trk      <= cfg_trk_coef;
            r_cfg_pending <= 1'b1;
        end else if (w_apply) begin
            r_act_ref     <= r_sh_ref;
            r_act_acq     <= r_sh_acq;
            r_act_trk     <= r_sh_trk;
            r_cfg_pending <= 1'b0;
        end
    end

    assign state       = r_state;
    assign ref_pow     = r_act_ref;
    assign error_coef  = r_error_coef;
    assign agc_rst     = r_agc_rst;
    assign locked      = r_locked;
    assign sat         = r_sat;
    assign cfg_pending = r_cfg_pending;

endmodule

// File: tb/tb_agc_ctrl.sv
// Directed bench for agc_ctrl: table of per-update vectors plus hand-written
// sequences for configuration shadowing, ACQ timeout and reset behaviour.
module tb_agc_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_ACQ   = 1;
    localparam int S_TRACK = 2;
    localparam int S_HOLD  = 3;
    localparam int ACQ_C   = 'h0011;
    localparam int TRK_C   = 'h0022;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable, freeze, cfg_we, gain_in_valid;
    logic [15:0]        cfg_ref_pow, cfg_acq_coef, cfg_trk_coef;
    logic signed [15:0] gain_in;
    logic [15:0]        ref_pow, error_coef;
    logic               agc_rst, locked, sat, cfg_pending;
    logic [1:0]         state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit    en;
        bit    frz;
        bit    vld;
        int    gain;
        int    st;
        bit    lck;
        int    coef;
        bit    arst;
        bit    sat;
        string nm;
    } vec_t;

    vec_t vecs[$];

    agc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .freeze        (freeze),
        .cfg_we        (cfg_we),
        .cfg_ref_pow   (cfg_ref_pow),
        .cfg_acq_coef  (cfg_acq_coef),
        .cfg_trk_coef  (cfg_trk_coef),
        .gain_in       (gain_in),
        .gain_in_valid (gain_in_valid),
        .ref_pow       (ref_pow),
        .error_coef    (error_coef),
        .agc_rst       (agc_rst),
        .state         (state),
        .locked        (locked),
        .sat           (sat),
        .cfg_pending   (cfg_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void add(input bit en, input bit frz, input bit vld, input int gain,
                                input int st, input bit lck, input int coef, input bit arst,
                                input bit s, input string nm);
        vecs.push_back('{en, frz, vld, gain, st, lck, coef, arst, s, nm});
    endfunction

    task automatic run_vecs();
        vec_t v;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            enable        = v.en;
            freeze        = v.frz;
            gain_in_valid = v.vld;
            gain_in       = 16'(v.gain);
            step();
            chk({v.nm, ".state"},  32'(state),      v.st);
            chk({v.nm, ".locked"}, 32'(locked),     32'(v.lck));
            chk({v.nm, ".coef"},   32'(error_coef), v.coef);
            chk({v.nm, ".agc_rst"},32'(agc_rst),    32'(v.arst));
            chk({v.nm, ".sat"},    32'(sat),        32'(v.sat));
        end
        gain_in_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ".state"},   32'(state),       S_IDLE);
        chk({nm, ".agc_rst"}, 32'(agc_rst),     1);
        chk({nm, ".coef"},    32'(error_coef),  0);
        chk({nm, ".ref"},     32'(ref_pow),     0);
        chk({nm, ".locked"},  32'(locked),      0);
        chk({nm, ".sat"},     32'(sat),         0);
        chk({nm, ".pending"}, 32'(cfg_pending), 0);
    endtask

    initial begin
        int pulses;
        int pulse_idx;
        int bad_state;

        rst_n = 1'b0;
        enable = 1'b0; freeze = 1'b0; cfg_we = 1'b0; gain_in_valid = 1'b0; gain_in = '0;
        cfg_ref_pow = '0; cfg_acq_coef = '0; cfg_trk_coef = '0;
        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
        repeat (3) step();

        // configuration in IDLE: pending for one cycle, then applied
        cfg_we = 1'b1; cfg_ref_pow = 16'h0100; cfg_acq_coef = 16'(ACQ_C); cfg_trk_coef = 16'(TRK_C);
        step();
        cfg_we = 1'b0;
        chk("cfg0.pending", 32'(cfg_pending), 1);
        chk("cfg0.ref",     32'(ref_pow), 0);
        step();
        chk("cfg1.pending", 32'(cfg_pending), 0);
        chk("cfg1.ref",     32'(ref_pow), 'h0100);
        chk("cfg1.state",   32'(state), S_IDLE);

        enable = 1'b1;
        step();
        chk("en.state",   32'(state), S_ACQ);
        chk("en.agc_rst", 32'(agc_rst), 0);
        chk("en.coef",    32'(error_coef), ACQ_C);

        // acquisition, lock, loss of lock, relock, freeze/unfreeze
        add(1,0,1,100, S_ACQ,0,ACQ_C,0,0, "acq_load");
        add(1,0,1,300, S_ACQ,0,ACQ_C,0,0, "acq_300");
        add(1,0,1,500, S_ACQ,0,ACQ_C,0,0, "acq_500");
        add(1,0,1,510, S_ACQ,0,ACQ_C,0,0, "acq_510");
        add(1,0,1,512, S_ACQ,0,ACQ_C,0,0, "acq_512");
        for (int k = 1; k <= 8; k++)
            add(1,0,1,512, (k >= 7) ? S_TRACK : S_ACQ, k >= 7, (k >= 7) ? TRK_C : ACQ_C, 0, 0,
                $sformatf("settle%0d", k));
        add(1,0,1,600, S_ACQ,0,ACQ_C,0,0, "lose_step");
        for (int k = 1; k <= 9; k++)
            add(1,0,1,600, (k == 9) ? S_TRACK : S_ACQ, k == 9, (k == 9) ? TRK_C : ACQ_C, 0, 0,
                $sformatf("relock%0d", k));
        add(1,1,1,5000, S_HOLD,1,0,0,0, "freeze0");
        add(1,1,1,9000, S_HOLD,1,0,0,0, "freeze1");
        add(1,0,0,0,    S_TRACK,1,TRK_C,0,0, "unfreeze");
        add(1,0,1,600,  S_TRACK,1,TRK_C,0,0, "post_hold");
        run_vecs();

        // cfg_we coinciding with a strobe defers to the next strobe
        cfg_we = 1'b1; cfg_ref_pow = 16'h0200; gain_in_valid = 1'b1; gain_in = 16'sd600;
        step();
        cfg_we = 1'b0; gain_in_valid = 1'b0;
        chk("defer0.pending", 32'(cfg_pending), 1);
        chk("defer0.ref",     32'(ref_pow), 'h0100);
        chk("defer0.state",   32'(state), S_TRACK);
        step();
        chk("defer1.pending", 32'(cfg_pending), 1);
        chk("defer1.state",   32'(state), S_TRACK);
        gain_in_valid = 1'b1;
        step();
        gain_in_valid = 1'b0;
        chk("apply.pending", 32'(cfg_pending), 0);
        chk("apply.ref",     32'(ref_pow), 'h0200);
        chk("apply.state",   32'(state), S_ACQ);
        chk("apply.locked",  32'(locked), 0);
        chk("apply.coef",    32'(error_coef), ACQ_C);

        // freeze in ACQ, then disable while still frozen
        add(1,1,0,0, S_HOLD,0,0,0,0, "acq_freeze");
        add(0,1,0,0, S_IDLE,0,0,1,0, "dis_frozen");
        run_vecs();
        freeze = 1'b0;

        // ACQ timeout: 256 unsettled updates give one single-cycle agc_rst
        enable = 1'b1;
        step();
        chk("to_start.state",   32'(state), S_ACQ);
        chk("to_start.agc_rst", 32'(agc_rst), 0);
        pulses = 0; pulse_idx = 0; bad_state = 0;
        for (int i = 1; i <= 256; i++) begin
            gain_in_valid = 1'b1;
            gain_in = (i % 2 == 1) ? 16'sd0 : 16'sd100;
            step();
            if (agc_rst === 1'b1) begin
                pulses++;
                pulse_idx = i;
            end
            if (state !== 2'(S_ACQ)) bad_state++;
        end
        gain_in_valid = 1'b0;
        step();
        chk("to.pulses",       32'(pulses), 1);
        chk("to.pulse_idx",    32'(pulse_idx), 256);
        chk("to.left_acq",     32'(bad_state), 0);
        chk("to_after.agc_rst",32'(agc_rst), 0);
        chk("to_after.state",  32'(state), S_ACQ);

        // saturation: 16 updates at GAIN_HIGH, then a normal one
        add(0,0,0,0, S_IDLE,0,0,1,0, "idle2");
        add(1,0,0,0, S_ACQ,0,ACQ_C,0,0, "acq2");
        for (int k = 1; k <= 16; k++)
            add(1,0,1,2048, (k >= 9) ? S_TRACK : S_ACQ, k >= 9, (k >= 9) ? TRK_C : ACQ_C, 0,
                k == 16, $sformatf("sat%0d", k));
        add(1,0,1,1000, S_ACQ,0,ACQ_C,0,0, "unsat");
        run_vecs();

        // asynchronous reset in ACQ with a pending config
        cfg_we = 1'b1; cfg_ref_pow = 16'h0300;
        step();
        cfg_we = 1'b0;
        chk("pre_rst.pending", 32'(cfg_pending), 1);
        chk("pre_rst.state",   32'(state), S_ACQ);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("sync.hold", 32'(state), S_IDLE);
        step();
        chk("sync.release", 32'(state), S_ACQ);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/agc_ctrl.md
AGC_CTRL -- requirements
Module: agc_ctrl

Interface
REQ-001 SHALL have parameter GAIN_WIDTH, default 16: width of gain_in, as signed fixed point.
REQ-002 SHALL have parameter GAIN_HIGH, default 2048: upper gain saturation threshold (raw integer).
REQ-003 SHALL have parameter GAIN_LOW, default 0: lower gain saturation threshold (raw integer).
REQ-004 SHALL have parameter SETTLE_TOL, default 4: maximum |delta gain| per update counted as settled.
REQ-005 SHALL have parameter SETTLE_COUNT, default 8: consecutive settled updates required to lock.
REQ-006 SHALL have parameter LOSE_TOL, default 64: |delta gain| above this value in TRACK drops lock.
REQ-007 SHALL have parameter ACQ_TIMEOUT, default 256: updates allowed in ACQ before an AGC restart.
REQ-008 SHALL have parameter SAT_COUNT, default 16: consecutive saturated updates required to raise sat.
REQ-009 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, all logic on its rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- enable, in, 1: run the AGC loop.
- freeze, in, 1: hold the current gain.
- cfg_we, in, 1: latch the three cfg_* words into shadow registers.
- cfg_ref_pow, in, 16: reference power.
- cfg_acq_coef, in, 16: error coefficient used in ACQ.
- cfg_trk_coef, in, 16: error coefficient used in TRACK.
- gain_in, in, GAIN_WIDTH, signed: gain from the AGC datapath.
- gain_in_valid, in, 1: gain update strobe.
- ref_pow, out, 16: reference power to the AGC.
- error_coef, out, 16: error coefficient to the AGC.
- agc_rst, out, 1: active-high reset to the AGC datapath.
- state, out, 2: current state.
- locked, out, 1: lock status.
- sat, out, 1: saturation flag.
- cfg_pending, out, 1: shadow configuration not yet applied.

Function
REQ-010 SHALL implement states IDLE=0, ACQ=1, TRACK=2, HOLD=3; all outputs registered, changing one cycle after the causing input edge.
REQ-011 In IDLE: agc_rst=1, error_coef=0, locked=0, sat=0. enable=1 SHALL move to ACQ, with agc_rst=0 in the same cycle state becomes ACQ.
REQ-012 enable=0 SHALL force IDLE from any state; this has priority over freeze and every other transition.
REQ-013 In ACQ, error_coef=active acq_coef. On each gain_in_valid: delta = gain_in - prev_gain, computed in GAIN_WIDTH+1 bits with no wrap; prev_gain is then updated.
REQ-014 The first gain_in_valid after entering ACQ SHALL only load prev_gain; no comparison is made.
REQ-015 Settle count: |delta| <= SETTLE_TOL increments settle_cnt, otherwise settle_cnt clears. settle_cnt reaching SETTLE_COUNT SHALL move to TRACK and set locked=1.
REQ-016 ACQ timeout: the update counter reaching ACQ_TIMEOUT without lock SHALL pulse agc_rst for exactly 1 cycle, clear all counters, and stay in ACQ.
REQ-017 In TRACK, error_coef=active trk_coef. |delta| > LOSE_TOL SHALL move to ACQ with locked=0 and counters cleared.
REQ-018 freeze=1 in ACQ or TRACK SHALL move to HOLD, with error_coef=0 and locked held. freeze=0 SHALL return to the state HOLD was entered from; gain_in_valid is ignored in HOLD.
REQ-019 cfg_we SHALL load the shadow registers and set cfg_pending=1; a second cfg_we before application overwrites the shadow.
REQ-020 Applying configuration: shadow is copied to active on the first gain_in_valid strictly after cfg_we (cfg_we and gain_in_valid in the same cycle defers to the next strobe), and cfg_pending clears. In IDLE or HOLD the copy happens on the next cycle.
REQ-021 An applied ref_pow that differs from the previous value while in TRACK SHALL move to ACQ with locked=0.
REQ-022 sat=1 after SAT_COUNT consecutive updates with gain_in >= GAIN_HIGH or gain_in <= GAIN_LOW; sat clears on the first non-saturated update.

Reset
REQ-023 rst_n=0 asynchronously: state=IDLE, agc_rst=1, error_coef=0, ref_pow=0, locked=0, sat=0, cfg_pending=0; active and shadow registers and all counters cleared.
REQ-024 Reset deassertion SHALL be synchronised (2-flop) before it releases the state machine.

Structure
REQ-025 Package agc_ctrl_pkg SHALL hold the state encoding constants and the parameter defaults.
REQ-026 Sub-module agc_settle_det SHALL contain prev_gain, the delta/abs logic, settle_cnt and sat_cnt, and output settled_hit, lost_hit and sat_hit.

Verification
REQ-027 enable=1, gain_in sequence 100,300,500,510,512 then 512 repeated 8 updates -> TRACK, locked=1, error_coef switches from acq_coef to trk_coef.
REQ-028 In TRACK, gain_in step 512->600 -> ACQ, locked=0, error_coef=acq_coef.
REQ-029 In ACQ, gain_in alternating 0/100 for 256 updates -> one 1-cycle agc_rst pulse, state stays ACQ.
REQ-030 cfg_we in the same cycle as gain_in_valid with ref_pow 0x0100->0x0200 -> cfg_pending=1 until the next strobe; then ref_pow=0x0200 and TRACK->ACQ.
REQ-031 freeze=1 in TRACK -> HOLD, error_coef=0; freeze=0 -> TRACK; enable=0 together with freeze=1 -> IDLE.
REQ-032 gain_in=2048 for 16 updates -> sat=1; next update 1000 -> sat=0; rst_n=0 mid-ACQ -> all outputs at reset values immediately.
